// File: rtl/spi_target_mode3_if.sv
// Local-side bus of the SPI mode-3 target: TX holding buffer handshake and RX word strobes.
interface spi_target_mode3_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_underrun;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_abort;

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_underrun, rx_data, rx_valid, rx_abort
    );

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_underrun, rx_data, rx_valid, rx_abort
    );
endinterface

// File: rtl/spi_target_mode3.sv
// SPI target, CPOL=1/CPHA=1, MSB first. Oversamples the SPI pins in the clk domain,
// returns a one-word TX buffer on MISO and strobes each received word to local logic.
module spi_target_mode3 #(
    parameter int unsigned          DATA_WIDTH   = 8,
    parameter int unsigned          SYNC_STAGES  = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE_WORD = {DATA_WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 SPI_CLK,
    input  logic                 SPI_EN,
    input  logic                 SPI_MOSI,
    output logic                 SPI_MISO,
    output logic                 SPI_MISO_OE,
    output logic                 busy,
    spi_target_mode3_if.slave    loc
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;

    state_e                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  clk_sync_q, en_sync_q, mosi_sync_q;
    logic                    clk_dly_q, en_dly_q;
    logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   tx_shift_q, tx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_WIDTH-1:0]   rx_data_q, rx_data_d;
    logic [DATA_WIDTH-1:0]   buf_data_q, buf_data_d;
    logic                    buf_full_q, buf_full_d;
    logic                    rx_valid_q, rx_valid_d;
    logic                    rx_abort_q, rx_abort_d;
    logic                    underrun_q, underrun_d;
    logic                    tx_ready_q, miso_q, oe_q, busy_q;

    logic clk_s, en_s, mosi_s;
    logic clk_rise_c, clk_fall_c, en_rise_c, en_fall_c;

    assign clk_s      = clk_sync_q[SYNC_STAGES-1];
    assign en_s       = en_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign clk_rise_c = clk_s & ~clk_dly_q;
    assign clk_fall_c = ~clk_s & clk_dly_q;
    assign en_rise_c  = en_s & ~en_dly_q;
    assign en_fall_c  = ~en_s & en_dly_q;

    // Input synchronizers, preset to the idle bus (clock high, enable low)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q  <= '1;
            en_sync_q   <= '0;
            mosi_sync_q <= '0;
            clk_dly_q   <= 1'b1;
            en_dly_q    <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], SPI_CLK};
            en_sync_q   <= {en_sync_q[SYNC_STAGES-2:0], SPI_EN};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            clk_dly_q   <= clk_s;
            en_dly_q    <= en_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            buf_data_q <= '0;
            buf_full_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_abort_q <= 1'b0;
            underrun_q <= 1'b0;
            tx_ready_q <= 1'b1;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            buf_data_q <= buf_data_d;
            buf_full_q <= buf_full_d;
            rx_valid_q <= rx_valid_d;
            rx_abort_q <= rx_abort_d;
            underrun_q <= underrun_d;
            tx_ready_q <= ~buf_full_d;
            miso_q     <= (state_d == SHIFT) & tx_shift_d[DATA_WIDTH-1];
            oe_q       <= (state_d != IDLE);
            busy_q     <= (state_d != IDLE);
        end
    end

    // Next-state: an EN fall overrides any SPI_CLK edge seen in the same cycle
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        buf_data_d = buf_data_q;
        buf_full_d = buf_full_q;
        rx_valid_d = 1'b0;
        rx_abort_d = 1'b0;
        underrun_d = 1'b0;

        if (loc.tx_valid && tx_ready_q) begin
            buf_full_d = 1'b1;
            buf_data_d = loc.tx_data;
        end

        if (en_fall_c) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            if (state_q == SHIFT && bit_cnt_q == CNT_W'(DATA_WIDTH)) begin
                rx_data_d  = rx_shift_q;
                rx_valid_d = 1'b1;
            end else if (bit_cnt_q != '0) begin
                rx_abort_d = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_rise_c) state_d = LOAD;
                end
                LOAD: begin
                    // Decided on the pre-write buffer state; a same-cycle write waits for the next word
                    if (buf_full_q) begin
                        tx_shift_d = buf_data_q;
                        buf_full_d = 1'b0;
                    end else begin
                        tx_shift_d = TX_IDLE_WORD;
                        underrun_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
                SHIFT: begin
                    if (bit_cnt_q == CNT_W'(DATA_WIDTH)) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = LOAD;
                    end else if (clk_fall_c) begin
                        if (bit_cnt_q != '0) tx_shift_d = tx_shift_q << 1;
                    end else if (clk_rise_c) begin
                        rx_shift_d = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};
                        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign SPI_MISO        = miso_q;
    assign SPI_MISO_OE     = oe_q;
    assign busy            = busy_q;
    assign loc.tx_ready    = tx_ready_q;
    assign loc.tx_underrun = underrun_q;
    assign loc.rx_data     = rx_data_q;
    assign loc.rx_valid    = rx_valid_q;
    assign loc.rx_abort    = rx_abort_q;
endmodule

// File: tb/tb_spi_target_mode3.sv
// Directed bench for spi_target_mode3: a mode-3 initiator model with 4-clk SPI_CLK half-periods.
module tb_spi_target_mode3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic SPI_CLK = 1'b1;
    logic SPI_EN = 1'b0;
    logic SPI_MOSI = 1'b0;
    logic SPI_MISO, SPI_MISO_OE, busy;

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int abort_cnt = 0;
    int under_cnt = 0;
    logic [7:0] rx_log [$];

    spi_target_mode3_if #(.DATA_WIDTH(8)) loc_if ();

    spi_target_mode3 #(.DATA_WIDTH(8), .SYNC_STAGES(2), .TX_IDLE_WORD(8'hFF)) dut (
        .clk(clk), .rst_n(rst_n), .SPI_CLK(SPI_CLK), .SPI_EN(SPI_EN), .SPI_MOSI(SPI_MOSI),
        .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE), .busy(busy), .loc(loc_if)
    );

    always #5 clk = ~clk;

    // Pulse monitor on the falling clk edge
    always @(negedge clk) begin
        if (loc_if.rx_valid) begin
            rx_cnt++;
            rx_log.push_back(loc_if.rx_data);
        end
        if (loc_if.rx_abort) abort_cnt++;
        if (loc_if.tx_underrun) under_cnt++;
        if (loc_if.rx_valid && loc_if.rx_abort) begin
            errors++;
            $display("FAIL valid_abort_overlap: rx_valid and rx_abort both 1 at %0t", $time);
        end
    end

    task automatic write_buf(input logic [7:0] d);
        int t = 0;
        while (!loc_if.tx_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (loc_if.tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL write_buf_timeout: tx_ready=%b required 1", loc_if.tx_ready);
        end else begin
            loc_if.tx_data  = d;
            loc_if.tx_valid = 1'b1;
            @(negedge clk);
            loc_if.tx_valid = 1'b0;
        end
    endtask

    // n mode-3 bits, MSB first; MISO sampled just before each rising SPI_CLK
    task automatic spi_bits(input logic [7:0] mosi, input int n, output logic [7:0] miso);
        miso = '0;
        for (int i = 0; i < n; i++) begin
            SPI_CLK  = 1'b0;
            SPI_MOSI = mosi[7-i];
            repeat (4) @(negedge clk);
            miso[7-i] = SPI_MISO;
            SPI_CLK = 1'b1;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic frame_begin();
        SPI_EN = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (2) @(negedge clk);
        SPI_EN = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if ({SPI_MISO, SPI_MISO_OE, busy, loc_if.tx_ready, loc_if.tx_underrun,
             loc_if.rx_valid, loc_if.rx_abort} !== 7'b0001000 || loc_if.rx_data !== 8'h00) begin
            errors++;
            $display("FAIL %s: miso=%b oe=%b busy=%b rdy=%b und=%b rv=%b ab=%b rx=%h required 0,0,0,1,0,0,0,00",
                     tag, SPI_MISO, SPI_MISO_OE, busy, loc_if.tx_ready, loc_if.tx_underrun,
                     loc_if.rx_valid, loc_if.rx_abort, loc_if.rx_data);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("post_reset_idle");
    endtask

    task automatic test_basic();
        logic [7:0] miso;
        int rx0, und0;
        rx0 = rx_cnt; und0 = under_cnt;
        write_buf(8'hA5);
        checks++;
        if (loc_if.tx_ready !== 1'b0) begin
            errors++; $display("FAIL basic_ready_drop: tx_ready=%b required 0", loc_if.tx_ready);
        end
        frame_begin();
        checks++;
        if ({loc_if.tx_ready, busy, SPI_MISO_OE} !== 3'b111 || under_cnt != und0) begin
            errors++;
            $display("FAIL basic_after_load: rdy/busy/oe=%b%b%b underruns=%0d required 111, %0d",
                     loc_if.tx_ready, busy, SPI_MISO_OE, under_cnt, und0);
        end
        spi_bits(8'h3C, 8, miso);
        checks++;
        if (miso !== 8'hA5) begin
            errors++; $display("FAIL basic_miso: got %h required a5", miso);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rx_cnt != rx0 + 1 || loc_if.rx_data !== 8'h3C) begin
            errors++;
            $display("FAIL basic_rx: rx_valid count %0d data %h required %0d, 3c", rx_cnt - rx0, loc_if.rx_data, 1);
        end
        frame_end();
        checks++;
        if (busy !== 1'b0 || SPI_MISO_OE !== 1'b0 || SPI_MISO !== 1'b0) begin
            errors++; $display("FAIL basic_end_idle: busy=%b oe=%b miso=%b required 0", busy, SPI_MISO_OE, SPI_MISO);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] miso;
        int und0;
        und0 = under_cnt;
        frame_begin();
        checks++;
        if (under_cnt != und0 + 1) begin
            errors++; $display("FAIL underrun_pulse: count %0d required 1", under_cnt - und0);
        end
        spi_bits(8'h00, 8, miso);
        checks++;
        if (miso !== 8'hFF) begin
            errors++; $display("FAIL underrun_miso: got %h required ff", miso);
        end
        frame_end();
        checks++;
        if (loc_if.rx_data !== 8'h00) begin
            errors++; $display("FAIL underrun_rx: got %h required 00", loc_if.rx_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] m0, m1;
        int base;
        base = rx_log.size();
        write_buf(8'h11);
        frame_begin();
        write_buf(8'h22);
        spi_bits(8'hDE, 8, m0);
        spi_bits(8'hAD, 8, m1);
        frame_end();
        checks++;
        if (m0 !== 8'h11 || m1 !== 8'h22) begin
            errors++; $display("FAIL b2b_miso: got %h,%h required 11,22", m0, m1);
        end
        checks++;
        if (rx_log.size() != base + 2) begin
            errors++; $display("FAIL b2b_rx_count: got %0d required 2", rx_log.size() - base);
        end else if (rx_log[base] !== 8'hDE || rx_log[base+1] !== 8'hAD) begin
            errors++; $display("FAIL b2b_rx_data: got %h,%h required de,ad", rx_log[base], rx_log[base+1]);
        end
    endtask

    task automatic test_abort();
        logic [7:0] miso;
        int rx0, ab0;
        rx0 = rx_cnt; ab0 = abort_cnt;
        frame_begin();
        spi_bits(8'hF0, 5, miso);
        frame_end();
        checks++;
        if (abort_cnt != ab0 + 1 || rx_cnt != rx0 || loc_if.rx_data !== 8'hAD) begin
            errors++;
            $display("FAIL abort: aborts %0d valids %0d rx %h required 1, 0, ad",
                     abort_cnt - ab0, rx_cnt - rx0, loc_if.rx_data);
        end
        frame_begin();
        spi_bits(8'h5A, 8, miso);
        frame_end();
        checks++;
        if (loc_if.rx_data !== 8'h5A || rx_cnt != rx0 + 1 || abort_cnt != ab0 + 1) begin
            errors++;
            $display("FAIL abort_recover: rx %h valids %0d aborts %0d required 5a, 1, 1",
                     loc_if.rx_data, rx_cnt - rx0, abort_cnt - ab0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] miso;
        int rx0, ab0, und0;
        write_buf(8'h77);
        frame_begin();
        spi_bits(8'hC3, 3, miso);
        rx0 = rx_cnt; ab0 = abort_cnt; und0 = under_cnt;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("reset_midframe_async");
        SPI_EN = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_idle_outputs("reset_midframe_after");
        checks++;
        if (rx_cnt != rx0 || abort_cnt != ab0 || under_cnt != und0) begin
            errors++; $display("FAIL reset_no_pulses: v/a/u deltas %0d/%0d/%0d required 0/0/0",
                               rx_cnt - rx0, abort_cnt - ab0, under_cnt - und0);
        end
    endtask

    task automatic test_random();
        logic [7:0] tx [4];
        logic [7:0] rx [4];
        logic [7:0] miso;
        int base;
        for (int f = 0; f < 25; f++) begin
            for (int k = 0; k < 4; k++) begin
                tx[k] = 8'($urandom);
                rx[k] = 8'($urandom);
            end
            base = rx_log.size();
            write_buf(tx[0]);
            frame_begin();
            for (int k = 0; k < 4; k++) begin
                if (k < 3) write_buf(tx[k+1]);
                spi_bits(rx[k], 8, miso);
                checks++;
                if (miso !== tx[k]) begin
                    errors++; $display("FAIL rand_miso f%0d w%0d: got %h required %h", f, k, miso, tx[k]);
                end
            end
            frame_end();
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (rx_log.size() <= base + k) begin
                    errors++; $display("FAIL rand_rx_missing f%0d w%0d: got none required %h", f, k, rx[k]);
                end else if (rx_log[base+k] !== rx[k]) begin
                    errors++; $display("FAIL rand_rx f%0d w%0d: got %h required %h", f, k, rx_log[base+k], rx[k]);
                end
            end
        end
    endtask

    initial begin
        loc_if.tx_data  = '0;
        loc_if.tx_valid = 1'b0;
        test_reset();
        test_basic();
        test_underrun();
        test_back_to_back();
        test_abort();
        test_reset_midframe();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
